// File: rtl/cdr_pkg.sv
// Shared types for the CDR lock sequencer.
//   cdr_state_t : sequencer state encoding (3-bit)
//   gain_t      : loop-gain shift amount sent to the CDR core (4-bit)
//   PHI_W       : width of the core's signed phase accumulator
package cdr_pkg;

    localparam int PHI_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_ACQ    = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } cdr_state_t;

    typedef logic [3:0] gain_t;

endpackage

// File: rtl/cdr_phase_delta.sv
// Symbol-to-symbol phase motion detector.
// Keeps the previous phase sample and, for every accepted strobe after the
// first one following a restart, reports whether the wrapped phase step
// exceeds the lock tolerance.
//   clk, rst   : clock and synchronous active-high reset
//   restart    : forget the stored sample; the next strobe only loads it
//   track      : strobes are accepted only while this is high
//   sym_valid  : symbol strobe from the core
//   phi        : signed phase accumulator from the core
//   d_valid    : a phase delta is being reported this cycle
//   viol       : |delta| > LOCK_TOL (meaningful only with d_valid)
module cdr_phase_delta
    import cdr_pkg::*;
#(
    parameter int LOCK_TOL = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restart,
    input  logic                    track,
    input  logic                    sym_valid,
    input  logic signed [PHI_W-1:0] phi,
    output logic                    d_valid,
    output logic                    viol
);

    localparam logic [PHI_W-1:0] TOL     = PHI_W'(LOCK_TOL);
    localparam logic [PHI_W-1:0] MOST_NEG = {1'b1, {(PHI_W-1){1'b0}}};
    localparam logic [PHI_W-1:0] MOST_POS = {1'b0, {(PHI_W-1){1'b1}}};

    logic [PHI_W-1:0] phi_prev;
    logic             primed;
    logic [PHI_W-1:0] delta;
    logic [PHI_W-1:0] mag;
    logic             take;

    assign take = sym_valid && track;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            primed <= 1'b0;
        end else if (take) begin
            primed <= 1'b1;
        end
        if (rst) begin
            phi_prev <= '0;
        end else if (take) begin
            phi_prev <= phi;
        end
    end

    // Two's-complement wrap is the natural behaviour of the modular subtract.
    // The most negative step has no positive counterpart, so it saturates.
    always_comb begin
        delta = phi - phi_prev;
        if (delta == MOST_NEG) begin
            mag = MOST_POS;
        end else if (delta[PHI_W-1]) begin
            mag = (~delta) + 1'b1;
        end else begin
            mag = delta;
        end
    end

    assign d_valid = take && primed;
    assign viol    = (mag > TOL);

endmodule

// File: rtl/cdr_lock_ctrl.sv
// Acquisition and lock sequencer for the baud-rate PAM4 CDR core.
// Holds the core in reset, runs high-gain acquisition, checks phase
// stability over a window, then tracks at low gain while watching for
// loss of lock. Gives up after MAX_RETRY failed verify windows.
//   clk, rst   : clock and synchronous active-high reset
//   en         : sequencer enable; low forces IDLE and clears all counters
//   sym_valid  : symbol strobe from the core
//   phi        : signed phase accumulator from the core
//   cdr_rst    : hold-in-reset to the core
//   kp_shift   : proportional gain shift to the core
//   ki_shift   : integral gain shift to the core
//   locked     : lock indication
//   fail       : acquisition failed; held until en goes low
//   lol_pulse  : single-cycle loss-of-lock pulse
//   state      : current sequencer state (debug)
//   retry_cnt  : failed verify attempts in this sequence
module cdr_lock_ctrl
    import cdr_pkg::*;
#(
    parameter int    CLR_CYCLES = 16,
    parameter int    ACQ_SYMS   = 1024,
    parameter int    WIN        = 256,
    parameter int    LOCK_TOL   = 64,
    parameter int    LOL_THRESH = 8,
    parameter int    MAX_RETRY  = 3,
    parameter gain_t KP_ACQ     = 4'd2,
    parameter gain_t KI_ACQ     = 4'd4,
    parameter gain_t KP_TRK     = 4'd5,
    parameter gain_t KI_TRK     = 4'd9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sym_valid,
    input  logic signed [PHI_W-1:0] phi,
    output logic                    cdr_rst,
    output logic [3:0]              kp_shift,
    output logic [3:0]              ki_shift,
    output logic                    locked,
    output logic                    fail,
    output logic                    lol_pulse,
    output logic [2:0]              state,
    output logic [1:0]              retry_cnt
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST = CNT_W'(ACQ_SYMS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN - 1);
    localparam logic [7:0]       LOL_T    = 8'(LOL_THRESH);
    localparam logic [1:0]       RETRY_T  = 2'(MAX_RETRY);

    cdr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       vcnt_q, vcnt_d, vcnt_inc;
    logic [1:0]       retry_q, retry_d, retry_inc;
    logic             lol_d;
    logic             track, restart, d_valid, viol;

    // Phase deltas are only of interest while verifying or tracking. Any
    // state change re-arms the detector so the first strobe in the new
    // state just loads the reference sample.
    assign track   = (state_q == ST_VERIFY) || (state_q == ST_LOCKED);
    assign restart = (state_d != state_q);

    cdr_phase_delta #(
        .LOCK_TOL (LOCK_TOL)
    ) u_delta (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .track     (track),
        .sym_valid (sym_valid),
        .phi       (phi),
        .d_valid   (d_valid),
        .viol      (viol)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vcnt_d    = vcnt_q;
        retry_d   = retry_q;
        lol_d     = 1'b0;
        vcnt_inc  = vcnt_q + {7'd0, viol};
        retry_inc = retry_q + 2'd1;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            vcnt_d  = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
                ST_CLR: begin
                    if (cnt_q == CLR_LAST) begin
                        state_d = ST_ACQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ACQ: begin
                    if (sym_valid) begin
                        if (cnt_q == ACQ_LAST) begin
                            state_d = ST_VERIFY;
                            cnt_d   = '0;
                            vcnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (d_valid) begin
                        if (cnt_q == WIN_LAST) begin
                            cnt_d  = '0;
                            vcnt_d = '0;
                            if (vcnt_inc == 8'd0) begin
                                state_d = ST_LOCKED;
                                retry_d = '0;
                            end else begin
                                retry_d = retry_inc;
                                state_d = (retry_inc == RETRY_T) ? ST_FAIL : ST_CLR;
                            end
                        end else begin
                            cnt_d  = cnt_q + 1'b1;
                            vcnt_d = vcnt_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (d_valid) begin
                        // Threshold is tested before window end so a hit on
                        // the last delta of a window still drops lock.
                        if (vcnt_inc == LOL_T) begin
                            state_d = ST_CLR;
                            lol_d   = 1'b1;
                            cnt_d   = '0;
                            vcnt_d  = '0;
                            retry_d = '0;
                        end else if (cnt_q == WIN_LAST) begin
                            cnt_d  = '0;
                            vcnt_d = '0;
                        end else begin
                            cnt_d  = cnt_q + 1'b1;
                            vcnt_d = vcnt_inc;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    vcnt_d  = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            vcnt_q    <= '0;
            retry_q   <= '0;
            cdr_rst   <= 1'b1;
            kp_shift  <= KP_ACQ;
            ki_shift  <= KI_ACQ;
            locked    <= 1'b0;
            fail      <= 1'b0;
            lol_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vcnt_q    <= vcnt_d;
            retry_q   <= retry_d;
            cdr_rst   <= (state_d == ST_IDLE) || (state_d == ST_CLR) || (state_d == ST_FAIL);
            if ((state_d == ST_VERIFY) || (state_d == ST_LOCKED)) begin
                kp_shift <= KP_TRK;
                ki_shift <= KI_TRK;
            end else begin
                kp_shift <= KP_ACQ;
                ki_shift <= KI_ACQ;
            end
            locked    <= (state_d == ST_LOCKED);
            fail      <= (state_d == ST_FAIL);
            lol_pulse <= lol_d;
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: doc/cdr_lock_ctrl.md
# cdr_lock_ctrl

Acquisition and lock sequencer for the baud-rate PAM4 CDR core. Holds the core in reset, then steps the loop through a high-gain acquisition phase, a verification window and low-gain tracking. It derives lock and loss-of-lock from symbol-to-symbol phase-accumulator motion, and gives up after a bounded number of failed attempts. It sits beside the CDR core in the top-level wrapper and drives the core's reset and loop-gain select inputs.

## Interface
- CLR_CYCLES, 16: clocks the core is held in reset per attempt
- ACQ_SYMS, 1024: symbol strobes spent in high-gain acquisition
- WIN, 256: phase deltas per verify/monitor window
- LOCK_TOL, 64: max allowed |Δphi| per symbol, in PHI LSBs
- LOL_THRESH, 8: violations within one LOCKED window that declare loss of lock
- MAX_RETRY, 3: failed verify attempts before FAIL
- KP_ACQ, 2 / KI_ACQ, 4: acquisition gain shifts (4-bit)
- KP_TRK, 5 / KI_TRK, 9: tracking gain shifts (4-bit)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  sequencer enable
- sym_valid  in  1  symbol strobe from the core (Sample_en)
- phi  in  16  signed phase accumulator from the core (PHI)
- cdr_rst  out  1  active-high hold-in-reset to the core
- kp_shift  out  4  proportional gain shift to the core
- ki_shift  out  4  integral gain shift to the core
- locked  out  1  lock indication
- fail  out  1  acquisition failed; sticky until en low
- lol_pulse  out  1  one-cycle loss-of-lock pulse
- state  out  3  current FSM state, for debug
- retry_cnt  out  2  failed verify attempts in the current sequence

## Operation
- States: IDLE=0, CLR=1, ACQ=2, VERIFY=3, LOCKED=4, FAIL=5.
- IDLE: cdr_rst=1, acquisition gains. Moves to CLR when en=1.
- CLR: cdr_rst=1. Counts CLR_CYCLES clocks, then moves to ACQ.
- ACQ: cdr_rst=0, KP_ACQ/KI_ACQ. Counts ACQ_SYMS strobes, then moves to VERIFY.
- VERIFY: KP_TRK/KI_TRK.
  - Collects WIN deltas.
  - If there are zero violations at window end, moves to LOCKED and clears retry_cnt.
  - Otherwise increments retry_cnt. If the new value equals MAX_RETRY, moves to FAIL; else moves to CLR.
- LOCKED: locked=1, tracking gains. Runs back-to-back WIN-delta windows; the violation count clears at each window start.
  - When the violation count reaches LOL_THRESH: lol_pulse=1 for one cycle, locked falls, state moves to CLR, and retry_cnt stays 0.
- FAIL: fail=1, cdr_rst=1. Stays in FAIL until en=0.
- en=0 in any state moves to IDLE on the next clock and clears all counters and retry_cnt.
- Delta rule:
  - Δ = phi − phi_prev, a 16-bit wrapping subtraction.
  - |Δ| saturates: −32768 gives 32767.
  - A violation is |Δ| > LOCK_TOL.
- The first strobe after entering VERIFY or LOCKED only loads phi_prev. It does not count toward WIN.
- sym_valid is ignored in IDLE, CLR and FAIL.

## Timing
- All outputs are registered and update on the clk edge following the causing event.
- Reset values: state=IDLE, cdr_rst=1, kp_shift=KP_ACQ, ki_shift=KI_ACQ, locked=0, fail=0, lol_pulse=0, retry_cnt=0.
- CLR lasts exactly CLR_CYCLES clocks; cdr_rst falls on the clock that enters ACQ.
- Gains switch on the same edge as the state change.
- Violation to lol_pulse: 1 clock after the LOL_THRESH-th violating strobe.
- Window end and threshold hit on the same strobe: the threshold (loss of lock) wins.
- rst and en=0 take priority over every transition. Mid-ACQ, mid-VERIFY and mid-LOCKED all abort cleanly.

## Structure
- Shared package cdr_pkg holds:
  - the state enum (3-bit)
  - the gain shift type (4-bit)
  - PHI_W=16
- One sub-module, cdr_phase_delta. It registers phi_prev and outputs a valid/violation pair per strobe, using wrap subtraction, saturating abs and compare.
- Everything else lives in the FSM.

## Test plan
- Reset, then en=1: cdr_rst high for exactly 16 clocks, then ACQ with kp=2/ki=4; after 1024 strobes, state=3 with kp=5/ki=9.
- Constant phi in VERIFY: after 1 load strobe + 256 strobes, locked=1, state=4, retry_cnt=0.
- One phi step of 65 per verify window, repeated: retry_cnt goes 1, 2, then FAIL with fail=1 and cdr_rst=1; en=0 returns to IDLE.
- In LOCKED, 8 violations within one window: one-cycle lol_pulse, locked=0, state=1. With 7 violations, locked stays 1.
- Wrap check: phi going 32767 → −32768 gives Δ=1, no violation. Phi 0 → −32768 gives |Δ|=32767, a violation.
- en dropped mid-ACQ, and rst mid-LOCKED: state=0 next clock, and all outputs equal their reset values.
